rcvr_frame_ctrl: RTL and testbench

- Sequencing controller that sits directly behind the serial receiver `rcvr`.
- Watches the receiver's READY flag and drives its ACK handshake: two ACK cycles per frame, high byte first, then low byte.
- Reassembles each 16-bit frame body and buffers it in a small frame FIFO.
- Presents frames to downstream logic over a valid/ready stream, with back-pressure toward the receiver, a frame counter and a sticky handshake-error flag.

---
 rtl/rcvr_frame_ctrl.sv | 107 ++++++++++
 tb/tb_rcvr_frame_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcvr_frame_ctrl.sv
// Drains 16-bit frames from the serial receiver via a two-beat ACK handshake and
// buffers them in a first-word-fall-through FIFO presented as a valid/ready stream.
module rcvr_frame_ctrl #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2,
    parameter int unsigned TMO   = 8
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        ready,
    input  logic [7:0]  dout,
    output logic        ack,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic [15:0] frame_data,
    output logic [7:0]  frame_cnt,
    output logic        full,
    output logic        err
);

    localparam int unsigned TW = $clog2(TMO + 1);

    typedef enum logic [1:0] {StIdle, StAck1, StAck2, StWaitLo} state_e;

    state_e        state_q;
    logic [7:0]    hi_q;
    logic [TW-1:0] tmo_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   rd_ptr_q;
    logic          push;
    logic          pop;
    logic          empty;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign frame_valid = !empty;
    assign frame_data  = empty ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
    assign push        = (state_q == StAck2);
    assign pop         = frame_valid && frame_ready;

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ack       <= 1'b0;
            hi_q      <= 8'h00;
            tmo_q     <= '0;
            frame_cnt <= 8'h00;
            err       <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ready && en && !full) begin
                        state_q <= StAck1;
                        ack     <= 1'b1;
                    end else begin
                        ack <= 1'b0;
                    end
                end
                StAck1: begin
                    hi_q    <= dout;
                    state_q <= StAck2;
                end
                StAck2: begin
                    frame_cnt <= frame_cnt + 8'd1;
                    ack       <= 1'b0;
                    tmo_q     <= '0;
                    state_q   <= StWaitLo;
                end
                StWaitLo: begin
                    // Never re-drain until READY has been seen low or the timeout fires.
                    if (!ready) begin
                        state_q <= StIdle;
                    end else if (tmo_q == TW'(TMO - 1)) begin
                        err     <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ack     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    // Low byte is taken straight from DOUT in the ACK2 cycle.
    always_ff @(posedge sclk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {hi_q, dout};
    end

endmodule

// File: tb/tb_rcvr_frame_ctrl.sv
// Directed bench for rcvr_frame_ctrl: a small receiver model drives READY/DOUT
// and a negedge monitor records every frame accepted downstream.
module tb_rcvr_frame_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int TMO   = 8;

    logic        sclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        ready = 1'b0;
    logic [7:0]  dout = 8'h00;
    logic        frame_ready = 1'b0;
    logic        ack;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic [7:0]  frame_cnt;
    logic        full;
    logic        err;

    int total = 0;
    int bad   = 0;
    logic [15:0] popped [$];

    rcvr_frame_ctrl #(.DEPTH(DEPTH), .AW(AW), .TMO(TMO)) dut (
        .sclk        (sclk),
        .rst_n       (rst_n),
        .en          (en),
        .ready       (ready),
        .dout        (dout),
        .ack         (ack),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_cnt   (frame_cnt),
        .full        (full),
        .err         (err)
    );

    always #5 sclk = ~sclk;

    // A frame seen valid&ready at the negedge is popped on the following posedge.
    always @(negedge sclk) begin
        if (rst_n && frame_valid && frame_ready) popped.push_back(frame_data);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0; ready = 1'b0; en = 1'b1; frame_ready = 1'b0; dout = 8'h00;
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        rst_n = 1'b1;
        popped.delete();
        @(negedge sclk);
    endtask

    // READY is already high with the high byte on DOUT; complete the handshake.
    task automatic finish_frame(input logic [7:0] lo, input bit hold, input bit drop_en);
        int n = 0;
        while (!ack && n < 200) begin
            @(posedge sclk); #1;
            n++;
        end
        if (!ack) begin
            total++; bad++;
            $display("FAIL ack_wait: ack got %0b want 1 within 200 cycles", ack);
            ready = 1'b0;
            return;
        end
        if (drop_en) en = 1'b0;
        @(posedge sclk); #1;
        dout = lo;
        @(posedge sclk); #1;
        if (!hold) begin
            ready = 1'b0;
            @(posedge sclk); #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo, input bit hold);
        @(negedge sclk);
        ready = 1'b1;
        dout  = hi;
        finish_frame(lo, hold, 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", ack); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", frame_valid); end
        total++; if (frame_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", frame_data); end
        total++; if (frame_cnt !== 8'h00) begin bad++; $display("FAIL rst_cnt: got %h want 00", frame_cnt); end
        total++; if ({full, err} !== 2'b00) begin bad++; $display("FAIL rst_full_err: got %b want 00", {full, err}); end
    endtask

    task automatic test_single();
        int late_ack = 0;
        do_reset();
        @(negedge sclk);
        ready = 1'b1; dout = 8'h3C;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL single_ack0: got %b want 0", ack); end
        @(posedge sclk); #1;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_ack1: got %b want 1", ack); end
        @(posedge sclk); #1;
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL single_ack2: got %b want 1", ack); end
        dout = 8'h5A;
        @(posedge sclk); #1;
        ready = 1'b0;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL single_ack3: got %b want 0", ack); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", frame_valid); end
        total++; if (frame_data !== 16'h3C5A) begin bad++; $display("FAIL single_data: got %h want 3c5a", frame_data); end
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL single_cnt: got %0d want 1", frame_cnt); end
        repeat (4) begin @(posedge sclk); #1; if (ack) late_ack++; end
        total++; if (late_ack !== 0) begin bad++; $display("FAIL single_no_extra_ack: got %0d want 0", late_ack); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec [4];
        vec = '{16'h1234, 16'hBEEF, 16'h0001, 16'hFFFF};
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_frame(vec[i][15:8], vec[i][7:0], 1'b0);
        repeat (4) @(posedge sclk);
        #1;
        total++; if (popped.size() !== 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", popped.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < popped.size()) begin
                total++;
                if (popped[i] !== vec[i]) begin bad++; $display("FAIL b2b_data%0d: got %h want %h", i, popped[i], vec[i]); end
            end
        end
        total++; if (frame_cnt !== 8'd4) begin bad++; $display("FAIL b2b_cnt: got %0d want 4", frame_cnt); end
        total++; if ({err, frame_valid} !== 2'b00) begin bad++; $display("FAIL b2b_err_valid: got %b want 00", {err, frame_valid}); end
    endtask

    task automatic test_backpressure();
        logic [15:0] vec [5];
        int ack_seen = 0;
        vec = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        do_reset();
        for (int i = 0; i < 3; i++) send_frame(vec[i][15:8], vec[i][7:0], 1'b0);
        total++; if (full !== 1'b0) begin bad++; $display("FAIL bp_not_full3: got %b want 0", full); end
        send_frame(vec[3][15:8], vec[3][7:0], 1'b0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL bp_full4: got %b want 1", full); end
        total++; if (frame_cnt !== 8'd4) begin bad++; $display("FAIL bp_cnt4: got %0d want 4", frame_cnt); end
        @(negedge sclk);
        ready = 1'b1; dout = vec[4][15:8];
        repeat (10) begin @(posedge sclk); #1; if (ack) ack_seen++; end
        total++; if (ack_seen !== 0) begin bad++; $display("FAIL bp_held: ack cycles got %0d want 0", ack_seen); end
        frame_ready = 1'b1;
        @(posedge sclk); #1;
        frame_ready = 1'b0;
        finish_frame(vec[4][7:0], 1'b0, 1'b0);
        frame_ready = 1'b1;
        repeat (8) @(posedge sclk);
        #1;
        total++; if (popped.size() !== 5) begin bad++; $display("FAIL bp_count: got %0d want 5", popped.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < popped.size()) begin
                total++;
                if (popped[i] !== vec[i]) begin bad++; $display("FAIL bp_data%0d: got %h want %h", i, popped[i], vec[i]); end
            end
        end
        total++; if (frame_cnt !== 8'd5) begin bad++; $display("FAIL bp_cnt5: got %0d want 5", frame_cnt); end
        total++; if ({full, frame_valid} !== 2'b00) begin bad++; $display("FAIL bp_drained: got %b want 00", {full, frame_valid}); end
    endtask

    task automatic test_en();
        int ack_seen = 0;
        do_reset();
        en = 1'b0;
        @(negedge sclk);
        ready = 1'b1; dout = 8'h9D;
        repeat (20) begin @(posedge sclk); #1; if (ack) ack_seen++; end
        total++; if (ack_seen !== 0) begin bad++; $display("FAIL en_low_ack: cycles got %0d want 0", ack_seen); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL en_low_cnt: got %0d want 0", frame_cnt); end
        en = 1'b1;
        finish_frame(8'h42, 1'b0, 1'b1);
        total++; if (frame_cnt !== 8'd1) begin bad++; $display("FAIL en_drop_cnt: got %0d want 1", frame_cnt); end
        total++; if (frame_data !== 16'h9D42) begin bad++; $display("FAIL en_drop_data: got %h want 9d42", frame_data); end
        en = 1'b1;
    endtask

    task automatic test_timeout();
        int ack_seen = 0;
        do_reset();
        send_frame(8'hC0, 8'hDE, 1'b1);
        repeat (TMO - 1) begin @(posedge sclk); #1; if (ack) ack_seen++; end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_early: err got %b want 0", err); end
        @(posedge sclk); #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_fire: err got %b want 1", err); end
        total++; if (ack_seen !== 0) begin bad++; $display("FAIL tmo_no_redrain: ack cycles got %0d want 0", ack_seen); end
        ready = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: err got %b want 1", err); end
        send_frame(8'h11, 8'h22, 1'b0);
        total++; if (frame_cnt !== 8'd2) begin bad++; $display("FAIL tmo_cnt: got %0d want 2", frame_cnt); end
        frame_ready = 1'b1;
        repeat (4) @(posedge sclk);
        #1;
        total++;
        if (popped.size() !== 2 || popped[0] !== 16'hC0DE || popped[1] !== 16'h1122) begin
            bad++;
            $display("FAIL tmo_frames: got size %0d [%h %h] want 2 [c0de 1122]", popped.size(),
                     (popped.size() > 0) ? popped[0] : 16'h0, (popped.size() > 1) ? popped[1] : 16'h0);
        end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_sticky2: err got %b want 1", err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(8'h55, 8'h66, 1'b0);
        @(negedge sclk);
        ready = 1'b1; dout = 8'h77;
        @(posedge sclk); #1;
        @(posedge sclk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL mid_ack: got %b want 0", ack); end
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt: got %0d want 0", frame_cnt); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", frame_valid); end
        ready = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        repeat (5) @(posedge sclk);
        #1;
        total++;
        if ({ack, frame_valid, frame_cnt} !== 10'd0) begin
            bad++; $display("FAIL mid_after: ack/valid/cnt got %b/%b/%0d want 0/0/0", ack, frame_valid, frame_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        frame_ready = 1'b1;
        for (int i = 0; i < 255; i++) send_frame(8'(i), ~8'(i), 1'b0);
        total++; if (frame_cnt !== 8'd255) begin bad++; $display("FAIL wrap_255: got %0d want 255", frame_cnt); end
        send_frame(8'hFF, 8'h00, 1'b0);
        total++; if (frame_cnt !== 8'd0) begin bad++; $display("FAIL wrap_0: got %0d want 0", frame_cnt); end
        repeat (4) @(posedge sclk);
        #1;
        total++; if (popped.size() !== 256) begin bad++; $display("FAIL wrap_pops: got %0d want 256", popped.size()); end
        if (popped.size() > 200) begin
            total++;
            if (popped[200] !== 16'hC837) begin bad++; $display("FAIL wrap_data200: got %h want c837", popped[200]); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_en();
        test_timeout();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
